// File: rtl/irq_ctrl_if.sv
// Peripheral register bus shared with the timer: chip select, address,
// write strobe, write data and registered read data.
interface irq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             cs;
  logic [2:0]       addr;
  logic             wen;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;

  modport master (output cs, addr, wen, din, input dout);
  modport slave  (input cs, addr, wen, din, output dout);
endinterface

// File: rtl/irq_ctrl.sv
// Prioritized interrupt controller: per-source sync/edge detect, pending,
// masking, lowest-index priority and a REQ/ack/EOI handshake to the CPU.

// One interrupt source: 2-flop synchronizer, edge history and edge pending.
module irq_src (
  input  logic clk,
  input  logic reset,
  input  logic irq_raw,
  input  logic mode,
  input  logic clr,
  output logic pend
);
  logic [2:0] sync_pipe;  // [0]=s1, [1]=s2, [2]=s3
  logic       edge_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_pipe <= '0;
      edge_pend <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[1:0], irq_raw};
      // A fresh edge outranks a simultaneous clear so it is never dropped.
      edge_pend <= (sync_pipe[1] & ~sync_pipe[2]) | (edge_pend & ~clr);
    end
  end

  assign pend = mode ? edge_pend : sync_pipe[1];
endmodule

module irq_ctrl #(
  parameter int WIDTH = 32,
  parameter int NIRQ  = 8
) (
  input  logic            clk,
  input  logic            reset,
  irq_ctrl_if.slave       bus,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            ack,
  output logic            cpu_irq,
  output logic [3:0]      irq_id
);
  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_MASK = 3'd1;
  localparam logic [2:0] REG_MODE = 3'd2;
  localparam logic [2:0] REG_PEND = 3'd3;
  localparam logic [2:0] REG_ID   = 3'd4;
  localparam logic [2:0] REG_EOI  = 3'd5;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t          state;
  logic            ctrl;
  logic [NIRQ-1:0] mask, mode, pend, clr, eff;
  logic [3:0]      top_id;
  logic [WIDTH-1:0] rdata;
  logic            wr, rd, wr_ctrl, wr_mask, wr_mode, wr_pend, wr_eoi, ack_hit;
  logic            unused_din;

  assign wr      = bus.cs & bus.wen;
  assign rd      = bus.cs & ~bus.wen;
  assign wr_ctrl = wr && (bus.addr == REG_CTRL);
  assign wr_mask = wr && (bus.addr == REG_MASK);
  assign wr_mode = wr && (bus.addr == REG_MODE);
  assign wr_pend = wr && (bus.addr == REG_PEND);
  assign wr_eoi  = wr && (bus.addr == REG_EOI);
  assign ack_hit = ack && (state == REQ);
  assign unused_din = ^bus.din;

  for (genvar i = 0; i < NIRQ; i++) begin : g_src
    // W1C and ack only affect the edge bit; a mode flip discards stale edges.
    assign clr[i] = (wr_pend & bus.din[i])
                  | (ack_hit & (irq_id == 4'(i)))
                  | (wr_mode & (bus.din[i] != mode[i]));

    irq_src u_src (
      .clk     (clk),
      .reset   (reset),
      .irq_raw (irq_in[i]),
      .mode    (mode[i]),
      .clr     (clr[i]),
      .pend    (pend[i])
    );
  end

  assign eff = ctrl ? (pend & mask) : '0;

  always_comb begin
    top_id = '0;
    for (int i = NIRQ - 1; i >= 0; i--)
      if (eff[i]) top_id = 4'(i);
  end

  always_comb begin
    rdata = '0;
    case (bus.addr)
      REG_CTRL: rdata[0]      = ctrl;
      REG_MASK: rdata[NIRQ-1:0] = mask;
      REG_MODE: rdata[NIRQ-1:0] = mode;
      REG_PEND: rdata[NIRQ-1:0] = pend;
      REG_ID: begin
        rdata[4]   = (state != IDLE);
        rdata[3:0] = irq_id;
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cpu_irq  <= 1'b0;
      irq_id   <= '0;
      ctrl     <= 1'b0;
      mask     <= '0;
      mode     <= '0;
      bus.dout <= '0;
    end else begin
      if (wr_ctrl) ctrl <= bus.din[0];
      if (wr_mask) mask <= bus.din[NIRQ-1:0];
      if (wr_mode) mode <= bus.din[NIRQ-1:0];
      if (rd)      bus.dout <= rdata;

      case (state)
        IDLE: if (eff != '0) begin
          irq_id  <= top_id;
          cpu_irq <= 1'b1;
          state   <= REQ;
        end
        // irq_id stays frozen here: no preemption by later arrivals.
        REQ: if (ack) begin
          cpu_irq <= 1'b0;
          state   <= SERVICE;
        end else if (wr_ctrl && !bus.din[0]) begin
          cpu_irq <= 1'b0;
          state   <= IDLE;
        end
        SERVICE: begin
          cpu_irq <= 1'b0;
          if (wr_eoi) state <= IDLE;
        end
        default: begin
          cpu_irq <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule
